mem_arbiter: RTL and testbench

Shares the single 128-bit main-memory port between the instruction cache and the data cache, which today each expect a private memory interface. Sits between both cache wrappers and the memory model/controller, latches one request at a time, and routes mem_ready back only to the granted cache. Arbitration is two-way round-robin, so neither fetch misses nor data misses/write-backs can starve the other.

---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/mem_arbiter_if.sv | 39 +++
 rtl/mem_arbiter_rr_pick2.sv | 21 ++
 rtl/mem_arbiter.sv | 79 +++++++
 tb/tb_mem_arbiter.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-cache main-memory arbiter.
package mem_arb_pkg;

    localparam int ADDR_W = 28;
    localparam int DATA_W = 128;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_I  = 2'd1,
        BUSY_D  = 2'd2,
        RELEASE = 2'd3
    } arb_state_t;

    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between icache, dcache, the arbiter and the memory port.
interface mem_arbiter_if;
    import mem_arb_pkg::*;

    logic              i_mem_read;
    logic [ADDR_W-1:0] i_mem_addr;
    logic [DATA_W-1:0] i_mem_rdata;
    logic              i_mem_ready;

    logic              d_mem_read;
    logic              d_mem_write;
    logic [ADDR_W-1:0] d_mem_addr;
    logic [DATA_W-1:0] d_mem_wdata;
    logic [DATA_W-1:0] d_mem_rdata;
    logic              d_mem_ready;

    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    // slave: the arbiter's view; master: caches plus memory around it
    modport slave (
        input  i_mem_read, i_mem_addr, d_mem_read, d_mem_write, d_mem_addr,
               d_mem_wdata, mem_rdata, mem_ready,
        output i_mem_rdata, i_mem_ready, d_mem_rdata, d_mem_ready,
               mem_read, mem_write, mem_addr, mem_wdata
    );

    modport master (
        output i_mem_read, i_mem_addr, d_mem_read, d_mem_write, d_mem_addr,
               d_mem_wdata, mem_rdata, mem_ready,
        input  i_mem_rdata, i_mem_ready, d_mem_rdata, d_mem_ready,
               mem_read, mem_write, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-requester round-robin pick: a tie goes to the side not granted last.
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic i_req,
    input  logic d_req,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant
);

    always_comb begin
        grant_valid = i_req | d_req;
        grant       = GRANT_I;
        if (i_req && d_req)
            grant = (last_grant == GRANT_D) ? GRANT_I : GRANT_D;
        else if (d_req)
            grant = GRANT_D;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between icache and dcache; one latched transaction
// at a time, ready routed only to the granted cache.
module mem_arbiter
    import mem_arb_pkg::*;
(
    input  logic          clk,
    input  logic          proc_reset,
    mem_arbiter_if.slave  bus
);

    arb_state_t        state, state_nxt;
    logic              last_grant;
    logic              grant_valid, grant, take_grant;
    logic              mem_read_q, mem_write_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;

    rr_pick2 u_pick (
        .i_req       (bus.i_mem_read),
        .d_req       (bus.d_mem_read | bus.d_mem_write),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant       (grant)
    );

    always_comb begin
        state_nxt  = state;
        take_grant = 1'b0;
        case (state)
            IDLE: begin
                if (grant_valid) begin
                    take_grant = 1'b1;
                    state_nxt  = (grant == GRANT_I) ? BUSY_I : BUSY_D;
                end
            end
            BUSY_I, BUSY_D: begin
                if (bus.mem_ready)
                    state_nxt = RELEASE;
            end
            RELEASE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (proc_reset) begin
            state       <= IDLE;
            last_grant  <= GRANT_D;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state <= state_nxt;
            if (take_grant) begin
                last_grant  <= grant;
                mem_addr_q  <= (grant == GRANT_D) ? bus.d_mem_addr : bus.i_mem_addr;
                // a dcache write wins over a simultaneous dcache read
                mem_read_q  <= (grant == GRANT_I) | ~bus.d_mem_write;
                mem_write_q <= (grant == GRANT_D) & bus.d_mem_write;
                if (grant == GRANT_D)
                    mem_wdata_q <= bus.d_mem_wdata;
            end else if (state_nxt == RELEASE) begin
                mem_read_q  <= 1'b0;
                mem_write_q <= 1'b0;
            end
        end
    end

    assign bus.mem_read    = mem_read_q;
    assign bus.mem_write   = mem_write_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wdata   = mem_wdata_q;
    assign bus.i_mem_ready = bus.mem_ready & (state == BUSY_I);
    assign bus.d_mem_ready = bus.mem_ready & (state == BUSY_D);
    assign bus.i_mem_rdata = bus.mem_rdata;
    assign bus.d_mem_rdata = bus.mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scenario tasks plus a randomized run against a cycle-count reference model.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic clk = 1'b0;
    logic proc_reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    mem_arbiter_if bus();

    mem_arbiter dut (
        .clk        (clk),
        .proc_reset (proc_reset),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.i_mem_read  = 1'b0;
        bus.i_mem_addr  = '0;
        bus.d_mem_read  = 1'b0;
        bus.d_mem_write = 1'b0;
        bus.d_mem_addr  = '0;
        bus.d_mem_wdata = '0;
        bus.mem_rdata   = '0;
        bus.mem_ready   = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        proc_reset = 1'b1;
        step();
        step();
        proc_reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0) begin errors++; $display("FAIL reset_cmd got rd=%0b wr=%0b exp 0 0", bus.mem_read, bus.mem_write); end
        checks++; if (bus.mem_addr !== '0 || bus.mem_wdata !== '0) begin errors++; $display("FAIL reset_addr_data got addr=%h wdata=%h exp 0", bus.mem_addr, bus.mem_wdata); end
        bus.mem_ready = 1'b1; #1;
        checks++; if (bus.i_mem_ready !== 1'b0 || bus.d_mem_ready !== 1'b0) begin errors++; $display("FAIL reset_idle_ready got i=%0b d=%0b exp 0 0", bus.i_mem_ready, bus.d_mem_ready); end
        bus.mem_ready = 1'b0;
    endtask

    task automatic test_icache_only();
        logic [DATA_W-1:0] rd;
        do_reset();
        bus.i_mem_read = 1'b1; bus.i_mem_addr = 28'h0000010;
        step();
        checks++; if (bus.mem_read !== 1'b1 || bus.mem_write !== 1'b0 || bus.mem_addr !== 28'h0000010) begin errors++; $display("FAIL ic_cmd got rd=%0b wr=%0b addr=%h exp 1 0 0000010", bus.mem_read, bus.mem_write, bus.mem_addr); end
        for (int k = 1; k <= 4; k++) begin
            rd = {$urandom, $urandom, $urandom, $urandom};
            bus.mem_rdata = rd; bus.mem_ready = (k == 4); #1;
            checks++; if (bus.i_mem_ready !== (k == 4) || bus.d_mem_ready !== 1'b0) begin errors++; $display("FAIL ic_ready k=%0d got i=%0b d=%0b exp %0b 0", k, bus.i_mem_ready, bus.d_mem_ready, (k == 4)); end
            checks++; if (bus.i_mem_rdata !== rd) begin errors++; $display("FAIL ic_rdata got %h exp %h", bus.i_mem_rdata, rd); end
            step();
        end
        bus.mem_ready = 1'b0; bus.i_mem_read = 1'b0;
        checks++; if (bus.mem_read !== 1'b0) begin errors++; $display("FAIL ic_release got rd=%0b exp 0", bus.mem_read); end
        step();
    endtask

    task automatic test_dcache_wb();
        logic [DATA_W-1:0] wd = {4{32'h11111111}};
        do_reset();
        bus.d_mem_write = 1'b1; bus.d_mem_addr = 28'h0ABCDEF; bus.d_mem_wdata = wd;
        step();
        checks++; if (bus.mem_write !== 1'b1 || bus.mem_read !== 1'b0 || bus.mem_addr !== 28'h0ABCDEF) begin errors++; $display("FAIL wb_cmd got rd=%0b wr=%0b addr=%h exp 0 1 0ABCDEF", bus.mem_read, bus.mem_write, bus.mem_addr); end
        checks++; if (bus.mem_wdata !== wd) begin errors++; $display("FAIL wb_wdata got %h exp %h", bus.mem_wdata, wd); end
        step();
        bus.mem_ready = 1'b1; #1;
        checks++; if (bus.d_mem_ready !== 1'b1 || bus.i_mem_ready !== 1'b0) begin errors++; $display("FAIL wb_ready got i=%0b d=%0b exp 0 1", bus.i_mem_ready, bus.d_mem_ready); end
        step();
        bus.mem_ready = 1'b0; bus.d_mem_write = 1'b0;
        checks++; if (bus.mem_write !== 1'b0) begin errors++; $display("FAIL wb_release got wr=%0b exp 0", bus.mem_write); end
        step();
    endtask

    task automatic test_tie_rr();
        logic [ADDR_W-1:0] a_i0 = 28'h0000100, a_d0 = 28'h0000200, a_i1 = 28'h0000300, a_d1 = 28'h0000400;
        do_reset();
        bus.i_mem_read = 1'b1; bus.i_mem_addr = a_i0; bus.d_mem_read = 1'b1; bus.d_mem_addr = a_d0;
        step();
        checks++; if (bus.mem_read !== 1'b1 || bus.mem_addr !== a_i0) begin errors++; $display("FAIL tie1 got rd=%0b addr=%h exp 1 %h", bus.mem_read, bus.mem_addr, a_i0); end
        bus.mem_ready = 1'b1; #1;
        checks++; if (bus.i_mem_ready !== 1'b1 || bus.d_mem_ready !== 1'b0) begin errors++; $display("FAIL tie1_ready got i=%0b d=%0b exp 1 0", bus.i_mem_ready, bus.d_mem_ready); end
        step();
        bus.mem_ready = 1'b0; bus.i_mem_read = 1'b0;
        step();
        bus.i_mem_read = 1'b1; bus.i_mem_addr = a_i1;
        checks++; if (bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0) begin errors++; $display("FAIL tie_gap got rd=%0b wr=%0b exp 0 0", bus.mem_read, bus.mem_write); end
        step();
        checks++; if (bus.mem_read !== 1'b1 || bus.mem_addr !== a_d0) begin errors++; $display("FAIL tie2 got rd=%0b addr=%h exp 1 %h", bus.mem_read, bus.mem_addr, a_d0); end
        bus.mem_ready = 1'b1; #1;
        checks++; if (bus.d_mem_ready !== 1'b1 || bus.i_mem_ready !== 1'b0) begin errors++; $display("FAIL tie2_ready got i=%0b d=%0b exp 0 1", bus.i_mem_ready, bus.d_mem_ready); end
        step();
        bus.mem_ready = 1'b0; bus.d_mem_read = 1'b0;
        step();
        bus.d_mem_read = 1'b1; bus.d_mem_addr = a_d1;
        step();
        checks++; if (bus.mem_read !== 1'b1 || bus.mem_addr !== a_i1) begin errors++; $display("FAIL tie3 got rd=%0b addr=%h exp 1 %h", bus.mem_read, bus.mem_addr, a_i1); end
        bus.mem_ready = 1'b1; #1;
        step();
        bus.mem_ready = 1'b0; bus.i_mem_read = 1'b0;
        step();
        step();
        checks++; if (bus.mem_read !== 1'b1 || bus.mem_addr !== a_d1) begin errors++; $display("FAIL tie4 got rd=%0b addr=%h exp 1 %h", bus.mem_read, bus.mem_addr, a_d1); end
        bus.mem_ready = 1'b1; #1;
        step();
        clear_inputs();
        step();
    endtask

    task automatic test_hold();
        do_reset();
        bus.i_mem_read = 1'b1; bus.i_mem_addr = 28'h0123456;
        step();
        for (int k = 0; k < 3; k++) begin
            bus.d_mem_addr = ADDR_W'($urandom);
            step();
            checks++; if (bus.mem_addr !== 28'h0123456 || bus.mem_read !== 1'b1) begin errors++; $display("FAIL hold_addr got rd=%0b addr=%h exp 1 0123456", bus.mem_read, bus.mem_addr); end
        end
        bus.mem_ready = 1'b1; #1;
        step();
        bus.i_mem_read = 1'b0; #1;
        checks++; if (bus.i_mem_ready !== 1'b0 || bus.d_mem_ready !== 1'b0) begin errors++; $display("FAIL hold_release_ready got i=%0b d=%0b exp 0 0", bus.i_mem_ready, bus.d_mem_ready); end
        step();
        checks++; if (bus.i_mem_ready !== 1'b0 || bus.d_mem_ready !== 1'b0 || bus.mem_read !== 1'b0) begin errors++; $display("FAIL hold_idle_ready got i=%0b d=%0b rd=%0b exp 0 0 0", bus.i_mem_ready, bus.d_mem_ready, bus.mem_read); end
        bus.mem_ready = 1'b0;
        step();
    endtask

    task automatic test_rw_both();
        do_reset();
        bus.d_mem_read = 1'b1; bus.d_mem_write = 1'b1; bus.d_mem_addr = 28'h0000777; bus.d_mem_wdata = {4{32'hCAFEF00D}};
        step();
        checks++; if (bus.mem_write !== 1'b1 || bus.mem_read !== 1'b0) begin errors++; $display("FAIL rw_both got rd=%0b wr=%0b exp 0 1", bus.mem_read, bus.mem_write); end
        bus.mem_ready = 1'b1; #1;
        step();
        clear_inputs();
        step();
    endtask

    task automatic test_reset_busy();
        do_reset();
        bus.d_mem_write = 1'b1; bus.d_mem_addr = 28'h0000ABC; bus.d_mem_wdata = {4{32'h5A5A5A5A}};
        step();
        bus.i_mem_read = 1'b1; bus.i_mem_addr = 28'h0000DEF;
        step();
        proc_reset = 1'b1;
        step();
        checks++; if (bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0 || bus.mem_addr !== '0 || bus.mem_wdata !== '0) begin errors++; $display("FAIL rst_busy_out got rd=%0b wr=%0b addr=%h wdata=%h exp all 0", bus.mem_read, bus.mem_write, bus.mem_addr, bus.mem_wdata); end
        bus.mem_ready = 1'b1; #1;
        checks++; if (bus.i_mem_ready !== 1'b0 || bus.d_mem_ready !== 1'b0) begin errors++; $display("FAIL rst_busy_ready got i=%0b d=%0b exp 0 0", bus.i_mem_ready, bus.d_mem_ready); end
        bus.mem_ready = 1'b0; proc_reset = 1'b0;
        step();
        checks++; if (bus.mem_read !== 1'b1 || bus.mem_write !== 1'b0 || bus.mem_addr !== 28'h0000DEF) begin errors++; $display("FAIL rst_busy_regrant got rd=%0b wr=%0b addr=%h exp 1 0 0000DEF", bus.mem_read, bus.mem_write, bus.mem_addr); end
        bus.mem_ready = 1'b1; #1;
        step();
        clear_inputs();
        step();
    endtask

    // Model: arbiter is free from two cycles after each completion; a free
    // arbiter with pending work issues the winner's command next cycle.
    task automatic test_random();
        bit i_req = 0, d_req = 0, d_wr = 0, i_cool = 0, d_cool = 0;
        bit busy = 0, owner_d = 0, last_d = 1, rdy = 0;
        bit exp_rd = 0, exp_wr = 0;
        int idle_at = 0, wait_n = 0, sel = 0;
        logic [ADDR_W-1:0] i_a = '0, d_a = '0, exp_a = '0;
        logic [DATA_W-1:0] d_wd = '0, exp_wd = '0, rd = '0;
        do_reset();
        for (int cyc = 0; cyc < 800; cyc++) begin
            checks++; if (bus.mem_read !== exp_rd || bus.mem_write !== exp_wr) begin errors++; $display("FAIL rnd_cmd cyc=%0d got rd=%0b wr=%0b exp %0b %0b", cyc, bus.mem_read, bus.mem_write, exp_rd, exp_wr); end
            if (exp_rd || exp_wr) begin
                checks++; if (bus.mem_addr !== exp_a) begin errors++; $display("FAIL rnd_addr cyc=%0d got %h exp %h", cyc, bus.mem_addr, exp_a); end
            end
            if (exp_wr) begin
                checks++; if (bus.mem_wdata !== exp_wd) begin errors++; $display("FAIL rnd_wdata cyc=%0d got %h exp %h", cyc, bus.mem_wdata, exp_wd); end
            end
            if (i_cool) i_cool = 0;
            else if (!i_req && $urandom_range(0, 2) == 0) begin i_req = 1; i_a = ADDR_W'($urandom); end
            if (d_cool) d_cool = 0;
            else if (!d_req && $urandom_range(0, 2) == 0) begin
                d_req = 1; d_a = ADDR_W'($urandom); d_wd = {$urandom, $urandom, $urandom, $urandom};
                sel = $urandom_range(0, 2);
            end
            d_wr = d_req && (sel != 0);
            bus.i_mem_read  = i_req; bus.i_mem_addr = i_a;
            bus.d_mem_read  = d_req && (sel != 1);
            bus.d_mem_write = d_wr;
            bus.d_mem_addr  = d_a; bus.d_mem_wdata = d_wd;
            rdy = 0;
            if (busy) begin if (wait_n == 0) rdy = 1; else wait_n--; end
            else rdy = ($urandom_range(0, 3) == 0);
            rd = {$urandom, $urandom, $urandom, $urandom};
            bus.mem_ready = rdy; bus.mem_rdata = rd;
            #1;
            checks++; if (bus.i_mem_ready !== (rdy && busy && !owner_d) || bus.d_mem_ready !== (rdy && busy && owner_d)) begin errors++; $display("FAIL rnd_ready cyc=%0d got i=%0b d=%0b exp %0b %0b", cyc, bus.i_mem_ready, bus.d_mem_ready, rdy && busy && !owner_d, rdy && busy && owner_d); end
            checks++; if (bus.i_mem_rdata !== rd || bus.d_mem_rdata !== rd) begin errors++; $display("FAIL rnd_rdata cyc=%0d got %h/%h exp %h", cyc, bus.i_mem_rdata, bus.d_mem_rdata, rd); end
            if (busy && rdy) begin
                busy = 0; idle_at = cyc + 2; exp_rd = 0; exp_wr = 0;
                if (owner_d) begin d_req = 0; d_cool = 1; end
                else begin i_req = 0; i_cool = 1; end
            end else if (!busy && cyc >= idle_at && (i_req || d_req)) begin
                owner_d = d_req && (!i_req || !last_d);
                last_d = owner_d; busy = 1; wait_n = $urandom_range(0, 4);
                if (owner_d) begin exp_wr = d_wr; exp_rd = !d_wr; exp_a = d_a; exp_wd = d_wd; end
                else begin exp_rd = 1; exp_wr = 0; exp_a = i_a; end
            end
            step();
        end
        clear_inputs();
        step();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_icache_only();
        test_dcache_wb();
        test_tie_rr();
        test_hold();
        test_rw_both();
        test_reset_busy();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
